// File: rtl/decode_stage_param.sv
// decode_stage_param: RV32I/RV32E instruction decode stage.
// Holds the register file, decodes controls and immediates, detects
// load-use and branch hazards, optionally resolves BEQ/BNE in ID, and
// registers the ID/EX bundle plus a saturating stall counter.
module decode_stage_param #(
    parameter int XLEN         = 32,
    parameter int NREGS        = 32,
    parameter int BRANCH_IN_ID = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] pc,
    input  logic            if_id_valid,
    input  logic            wb_write_enable,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_reg_write,
    input  logic            ex_mem_read,
    input  logic [4:0]      ex_rd,
    input  logic            mem_reg_write,
    input  logic            mem_mem_read,
    input  logic [4:0]      mem_rd,
    input  logic [XLEN-1:0] mem_result,
    output logic            pc_enable,
    output logic            if_id_enable,
    output logic            if_id_flush,
    output logic            pc_branch_taken,
    output logic [XLEN-1:0] pc_branch_value,
    output logic            id_ex_valid,
    output logic            mem_to_reg_out,
    output logic            reg_write_out,
    output logic            mem_read_out,
    output logic            mem_write_out,
    output logic            beq_instruction_out,
    output logic            bne_instruction_out,
    output logic            aluSrc_out,
    output logic [1:0]      aluOp_out,
    output logic [4:0]      rs1_out,
    output logic [4:0]      rs2_out,
    output logic [4:0]      rd_out,
    output logic [XLEN-1:0] rs1_data_out,
    output logic [XLEN-1:0] rs2_data_out,
    output logic [XLEN-1:0] imediato_out,
    output logic [XLEN-1:0] pc_out,
    output logic [15:0]     stall_count
);

    localparam int IDXW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef struct packed {
        logic            valid;
        logic            mem_to_reg;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            beq;
        logic            bne;
        logic            alu_src;
        logic [1:0]      alu_op;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
    } idex_t;

    logic [XLEN-1:0] regs [NREGS];
    idex_t           idex_q, idex_d;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [4:0]      rs1, rs2, rd;
    logic            is_r, is_i, is_lw, is_sw, is_br, dec, use2;
    logic [XLEN-1:0] imm, imm_b, rs1_val, rs2_val, br_a, br_b;
    logic            load_use, br_stall, stall, taken;

    // Indices outside the register count read 0; WB data is bypassed
    // so an instruction reading a register being written sees the new value.
    function automatic logic [XLEN-1:0] read_rf(input logic [4:0] a);
        logic [XLEN-1:0] v;
        v = '0;
        if (a != 5'd0 && int'(a) < NREGS) begin
            if (wb_write_enable && wb_rd == a) v = wb_data;
            else                               v = regs[a[IDXW-1:0]];
        end
        return v;
    endfunction

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign rd     = instruction[11:7];

    assign is_r  = opcode == 7'b0110011;
    assign is_i  = opcode == 7'b0010011;
    assign is_lw = opcode == 7'b0000011;
    assign is_sw = opcode == 7'b0100011;
    assign is_br = opcode == 7'b1100011 && (funct3 == 3'b000 || funct3 == 3'b001);
    assign dec   = if_id_valid && (is_r || is_i || is_lw || is_sw || is_br);
    assign use2  = dec && (is_r || is_sw || is_br);

    assign imm_b = {{(XLEN-12){instruction[31]}}, instruction[7],
                    instruction[30:25], instruction[11:8], 1'b0};
    assign pc_branch_value = pc + imm_b;

    // Immediate selection by instruction format
    always_comb begin
        imm = '0;
        if (is_i || is_lw) imm = {{(XLEN-12){instruction[31]}}, instruction[31:20]};
        else if (is_sw)    imm = {{(XLEN-12){instruction[31]}}, instruction[31:25], instruction[11:7]};
        else if (is_br)    imm = imm_b;
    end

    assign rs1_val = read_rf(rs1);
    assign rs2_val = read_rf(rs2);

    assign load_use = ex_mem_read && ex_rd != 5'd0 &&
                      ((dec && ex_rd == rs1) || (use2 && ex_rd == rs2));

    // Branch hazards, MEM forwarding and in-ID resolution; stall beats taken
    always_comb begin
        br_stall = 1'b0;
        br_a     = rs1_val;
        br_b     = rs2_val;
        taken    = 1'b0;
        if (BRANCH_IN_ID != 0 && dec && is_br) begin
            br_stall = (ex_reg_write && ex_rd != 5'd0 && (ex_rd == rs1 || ex_rd == rs2)) ||
                       (mem_mem_read && mem_rd != 5'd0 && (mem_rd == rs1 || mem_rd == rs2));
            if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs1) br_a = mem_result;
            if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs2) br_b = mem_result;
            taken = !(load_use || br_stall) &&
                    ((funct3 == 3'b000) ? (br_a == br_b) : (br_a != br_b));
        end
    end

    assign stall           = load_use || br_stall;
    assign pc_enable       = reset && !stall;
    assign if_id_enable    = reset && !stall;
    assign if_id_flush     = reset && taken;
    assign pc_branch_taken = reset && taken;

    // Next ID/EX bundle: bubble on stall, taken branch or undecoded slot.
    // With in-ID resolution the branch flags stay 0 so EX never re-resolves.
    always_comb begin
        idex_d = '0;
        if (dec && !stall && !taken) begin
            idex_d.valid      = 1'b1;
            idex_d.reg_write  = is_r || is_i || is_lw;
            idex_d.mem_read   = is_lw;
            idex_d.mem_to_reg = is_lw;
            idex_d.mem_write  = is_sw;
            idex_d.alu_src    = is_i || is_lw || is_sw;
            idex_d.alu_op     = is_r ? 2'b10 : is_i ? 2'b11 : is_br ? 2'b01 : 2'b00;
            idex_d.beq        = BRANCH_IN_ID == 0 && is_br && funct3 == 3'b000;
            idex_d.bne        = BRANCH_IN_ID == 0 && is_br && funct3 == 3'b001;
            idex_d.rs1        = rs1;
            idex_d.rs1_data   = rs1_val;
            idex_d.rs2        = use2 ? rs2 : 5'd0;
            idex_d.rs2_data   = use2 ? rs2_val : '0;
            idex_d.rd         = (is_r || is_i || is_lw) ? rd : 5'd0;
            idex_d.imm        = imm;
            idex_d.pc         = pc;
        end
    end

    // Register file write port; x0 and out-of-range indices are dropped
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wb_write_enable && wb_rd != 5'd0 && int'(wb_rd) < NREGS) begin
            regs[wb_rd[IDXW-1:0]] <= wb_data;
        end
    end

    // ID/EX pipeline register and saturating stall counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idex_q      <= '0;
            stall_count <= '0;
        end else begin
            idex_q <= idex_d;
            if (stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
        end
    end

    assign id_ex_valid         = idex_q.valid;
    assign mem_to_reg_out      = idex_q.mem_to_reg;
    assign reg_write_out       = idex_q.reg_write;
    assign mem_read_out        = idex_q.mem_read;
    assign mem_write_out       = idex_q.mem_write;
    assign beq_instruction_out = idex_q.beq;
    assign bne_instruction_out = idex_q.bne;
    assign aluSrc_out          = idex_q.alu_src;
    assign aluOp_out           = idex_q.alu_op;
    assign rs1_out             = idex_q.rs1;
    assign rs2_out             = idex_q.rs2;
    assign rd_out              = idex_q.rd;
    assign rs1_data_out        = idex_q.rs1_data;
    assign rs2_data_out        = idex_q.rs2_data;
    assign imediato_out        = idex_q.imm;
    assign pc_out              = idex_q.pc;

endmodule

// File: doc/decode_stage_param.md
# decode_stage_param

Parametrised RV32I/RV32E instruction-decode stage sitting between the IF/ID and ID/EX pipeline registers. It contains:
- the architectural register file;
- control decode and immediate generation;
- load-use and branch hazard detection;
- optional early (in-ID) BEQ/BNE resolution with forwarding from EX/MEM;
- a registered ID/EX output bundle and a saturating stall counter.

It replaces the fixed 32-bit decode stage; width, register count and branch-resolution point are now parameters.

## Interface
- XLEN, 32, datapath width (32 or 64); immediates sign-extend to XLEN.
- NREGS, 32, architectural registers (32 = RV32I, 16 = RV32E); indices ≥ NREGS read 0 and ignore writes.
- BRANCH_IN_ID, 1, 1 = resolve BEQ/BNE in ID; 0 = pass branch flags to EX, pc_branch_taken held 0.
- clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; low clears all state immediately.
- instruction  in  32  instruction from IF/ID.
- pc  in  XLEN  PC of that instruction.
- if_id_valid  in  1  0 = IF/ID holds a bubble.
- wb_write_enable, wb_rd, wb_data  in  1/5/XLEN  register-file write port from WB.
- ex_reg_write, ex_mem_read, ex_rd  in  1/1/5  instruction currently in EX.
- mem_reg_write, mem_mem_read, mem_rd, mem_result  in  1/1/5/XLEN  instruction currently in MEM.
- pc_enable, if_id_enable  out  1  0 = hold PC and IF/ID (stall).
- if_id_flush  out  1  squash IF/ID next edge (taken branch).
- pc_branch_taken  out  1  select pc_branch_value as next PC.
- pc_branch_value  out  XLEN  pc + B-immediate, always computed.
- id_ex_valid, mem_to_reg_out, reg_write_out, mem_read_out, mem_write_out, beq_instruction_out, bne_instruction_out, aluSrc_out  out  1  registered controls.
- aluOp_out  out  2  00 load/store, 01 branch, 10 R-type, 11 I-ALU.
- rs1_out, rs2_out, rd_out  out  5  registered register indices.
- rs1_data_out, rs2_data_out, imediato_out, pc_out  out  XLEN  registered operands, immediate, PC.
- stall_count  out  16  saturating count of stall cycles.

## Operation
**Decode.** Decoded opcodes: 0110011 (R), 0010011 (I-ALU), 0000011 (LW), 0100011 (SW), 1100011 (branch; funct3 000 = BEQ, 001 = BNE).
- Any other opcode, or if_id_valid = 0: bubble (all controls 0, id_ex_valid = 0, rd_out = 0).
- Immediate formats: I for I-ALU and LW, S for SW, B (bit0 = 0) for branches; R-type imediato_out = 0.
- rs1 is used by all decoded types; rs2 only by R, SW and branch.

**Register file.**
- x0 reads 0.
- Write on rising edge when wb_write_enable & wb_rd ≠ 0 & wb_rd < NREGS.
- A same-cycle read of wb_rd returns wb_data (write-through bypass).

**Load-use hazard.** Stall when ex_mem_read & ex_rd ≠ 0 & ex_rd matches a used source.

**Branch hazard (BRANCH_IN_ID = 1, branch instructions only).**
- Stall when ex_reg_write & ex_rd ≠ 0 & ex_rd matches rs1 or rs2.
- Stall when mem_mem_read & mem_rd ≠ 0 & mem_rd matches rs1 or rs2.
- Otherwise forward mem_result for any source matching mem_rd (mem_reg_write, mem_rd ≠ 0). Priority: MEM forward > WB bypass > register file.

**Stall.** pc_enable = if_id_enable = 0; ID/EX loads a bubble; stall_count += 1, saturating at 0xFFFF.

**Taken branch.** Taken when not stalled and (BEQ & equal) or (BNE & not equal). Then pc_branch_taken = 1 and if_id_flush = 1; the branch itself enters ID/EX as a bubble.

**BRANCH_IN_ID = 0.** No branch hazard logic. beq_instruction_out / bne_instruction_out are registered for resolution in EX.

**Simultaneous stall and branch condition.** The stall wins: taken = 0, flush = 0.

## Timing
- Hazard and branch outputs are combinational from the current inputs and register-file state. With no stall, pc_enable = if_id_enable = 1.
- ID/EX outputs have 1-cycle latency: they reflect the instruction in ID at the preceding rising edge.
- While reset is low:
  - register file, all ID/EX outputs and stall_count are 0;
  - pc_enable, if_id_enable, if_id_flush and pc_branch_taken are forced to 0.
- Reset asserted mid-stall or mid-branch aborts the operation. The first edge after release decodes the current instruction normally.
- The load-use stall lasts exactly 1 cycle.
- A branch depending on a load in EX stalls 2 cycles; a branch depending on an ALU result in EX stalls 1 cycle.

## Test plan
- **Reset and write bypass.** Hold reset low, then release. Write x5 = 0x1234 via WB; in the same cycle decode ADD x1,x5,x0. Required: all outputs 0 during reset; rs1_data_out = 0x1234 next cycle; a write to x0 leaves x0 reading 0.
- **Immediate formats.** Decode ADDI x2,x0,-1 → imediato_out = 0xFFFFFFFF, aluOp_out = 11, aluSrc_out = 1. Decode SW x3,8(x4) → imm = 8, mem_write_out = 1.
- **Load-use stall.** EX holds LW x7 (ex_mem_read = 1, ex_rd = 7); ID decodes ADD x8,x7,x1. Required: pc_enable = if_id_enable = 0 for one cycle, bubble in ID/EX, stall_count = 1. The ADD issues on the next cycle.
- **Branch in ID with forwarding.** x1 = 5, mem_result = 5 for mem_rd = 2; decode BEQ x1,x2,+16 at pc 0x100. Required: pc_branch_taken = 1, pc_branch_value = 0x110, if_id_flush = 1.
- **BNE stalls behind a load.** BNE x1,x2 while LW x2 sits in EX and then moves to MEM. Required: 2 stall cycles; resolves not-taken with equal operands.
- **Mode and RV32E.** BRANCH_IN_ID = 0 → pc_branch_taken stays 0 and beq_instruction_out = 1 after 1 cycle. NREGS = 16: a write to x20 is ignored and a read of x20 returns 0.
